uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter: accepts bytes from on-chip logic through a write strobe, queues them in a DEPTH-entry FIFO and serialises them 8N1 (LSB first) on one TX line. Frames go out back-to-back with no idle gap between them. It is the outbound end of the UART link, fed by the sort FSM with result bytes. It is checked end-to-end against `uart_rx` in loopback.

## Interface

Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit (10 MHz / 115200 baud); legal range 2..65535
- DEPTH, 8, FIFO entries; power of two, ≥2
- ADDR_W, 3, log2(DEPTH)

Ports:
- i_Clock  in  1  system clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Wr_DV  in  1  write strobe, one byte per high cycle
- i_Wr_Byte  in  8  byte to queue
- o_Full  out  1  FIFO holds DEPTH entries
- o_Empty  out  1  FIFO holds 0 entries
- o_Count  out  ADDR_W+1  FIFO occupancy, 0..DEPTH
- o_Overflow  out  1  sticky: a write was dropped
- o_Tx_Serial  out  1  serial line, idle high
- o_Tx_Active  out  1  high while a frame is on the line
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame

## Operation

- FIFO: circular buffer with ADDR_W-bit read/write pointers that wrap from DEPTH-1 to 0, plus an ADDR_W+1-bit count.
- Write is accepted when i_Wr_DV=1 and registered o_Full=0.
- Write while o_Full=1 is dropped, even if a pop occurs in the same cycle. It sets o_Overflow, which clears only on reset.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- FSM states:
  - IDLE: line 1. If count≠0, pop head into shift register and go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: line = shift[0] for CLKS_PER_BIT cycles per bit, 8 bits, LSB first. Bit index 0..7. After bit 7, go to PARITY (macro defined) or STOP.
  - PARITY: line = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles. On its last cycle, pulse o_Tx_Done. Then:
    - if count≠0, pop and go directly to START (back-to-back frames);
    - else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state change. Its width is sized for 65535.
- o_Tx_Active = 1 in START, DATA, PARITY and STOP.
- i_Wr_Byte is sampled only on the accept edge. The byte being transmitted is held in the shift register, so it is unaffected by later writes.

## Timing

- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Empty=1, o_Full=0, o_Count=0, o_Overflow=0. FSM returns to IDLE and pointers to 0.
- Reset asserted mid-frame: o_Tx_Serial goes to 1 immediately (asynchronous). FIFO contents are discarded, and the partial frame is not resumed.
- Write accepted at edge k while IDLE and empty:
  - o_Count=1 after edge k;
  - pop and o_Tx_Serial=0 after edge k+1.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- o_Tx_Done is high for exactly one cycle, the final cycle of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle after the Done cycle, with zero idle cycles.
- All outputs are registered. o_Full, o_Empty and o_Count reflect state after the last edge.

## Configuration

- UART_TX_PARITY_EN
  - Defined: the PARITY state is included; frames are 8E1 (11 bits).
  - Undefined: the PARITY state and its logic are absent; frames are 8N1 (10 bits).
- Receiver-side loopback tests with parity require a matching receiver setting.

## Test plan

All tests use CLKS_PER_BIT=87 and a 100 ns clock.

- **Reset values:** assert i_Reset asynchronously → all outputs at their reset values without a clock edge.
- **Single byte 0xAB:**
  - line 0 for 87 cycles, then bits 1,1,0,1,0,1,0,1 (87 cycles each), then stop 1;
  - o_Tx_Done pulses 870 cycles after the start bit begins;
  - uart_rx loopback returns 0xAB.
- **Burst and overflow:** 10 consecutive writes 0x00..0x09 from IDLE →
  - 0x00 is popped at the second edge; 0x01..0x08 are queued (o_Count=8, o_Full=1);
  - 0x09 is dropped and o_Overflow=1;
  - loopback receives 0x00..0x08 in order with zero gap between frames.
- **Simultaneous push/pop:** while o_Count=3, write on the pop cycle (STOP→START) → o_Count stays 3, data order preserved.
- **Reset mid-DATA of 0x3F:** o_Tx_Serial=1 immediately, o_Count=0. A new write of 0x55 after reset transmits a clean frame with 0x55 received.
- **UART_TX_PARITY_EN defined:**
  - 0x07 → parity bit 1, frame 957 cycles;
  - 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first, back-to-back frames).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 frames).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done
);

  localparam logic [15:0]     BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     BAUD_DONE  = 16'(CLKS_PER_BIT - 2);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;

  state_t            state_q;
  logic [15:0]       baud_q;
  logic [2:0]        bitIdx_q;
  logic [7:0]        shift_q;
  logic              txSerial_q;
  logic              txActive_q;
  logic              txDone_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic              push;
  logic              pop;
  logic [7:0]        headByte;

  // A pop happens when the line is free: from IDLE, or on the last stop-bit cycle.
  always_comb begin
    push     = i_Wr_DV && !full_q;
    pop      = (count_q != '0) &&
               ((state_q == IDLE) || ((state_q == STOP) && (baud_q == BAUD_LAST)));
    headByte = mem_q[rdPtr_q];
  end

  always_comb begin
    wrPtr_d    = push ? wrPtr_q + ADDR_W'(1) : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + ADDR_W'(1) : rdPtr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    full_d     = (count_d == FULL_COUNT);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q || (i_Wr_DV && full_q);
  end

  // Storage has no reset: pointers and count define which entries are valid.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wrPtr_q] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Line value is registered one state ahead so it changes exactly on bit boundaries.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      txSerial_q <= 1'b1;
      txActive_q <= 1'b0;
      txDone_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      txDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q     <= '0;
          txSerial_q <= 1'b1;
          txActive_q <= 1'b0;
          if (pop) begin
            shift_q    <= headByte;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^headByte;
`endif
            state_q    <= START;
            txSerial_q <= 1'b0;
            txActive_q <= 1'b1;
          end
        end

        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q     <= '0;
            bitIdx_q   <= '0;
            state_q    <= DATA;
            txSerial_q <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q    <= PARITY;
              txSerial_q <= parity_q;
`else
              state_q    <= STOP;
              txSerial_q <= 1'b1;
`endif
            end else begin
              bitIdx_q   <= bitIdx_q + 3'd1;
              shift_q    <= {1'b0, shift_q[7:1]};
              txSerial_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_q == BAUD_LAST) begin
            baud_q     <= '0;
            state_q    <= STOP;
            txSerial_q <= 1'b1;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
`endif

        STOP: begin
          if (baud_q == BAUD_DONE) begin
            txDone_q <= 1'b1;
          end
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (pop) begin
              shift_q    <= headByte;
`ifdef UART_TX_PARITY_EN
              parity_q   <= ^headByte;
`endif
              state_q    <= START;
              txSerial_q <= 1'b0;
            end else begin
              state_q    <= IDLE;
              txSerial_q <= 1'b1;
              txActive_q <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        default: begin
          state_q    <= IDLE;
          baud_q     <= '0;
          txSerial_q <= 1'b1;
          txActive_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Full      = full_q;
  assign o_Empty     = empty_q;
  assign o_Count     = count_q;
  assign o_Overflow  = overflow_q;
  assign o_Tx_Serial = txSerial_q;
  assign o_Tx_Active = txActive_q;
  assign o_Tx_Done   = txDone_q;

endmodule
